ofdm_symbol_framer: RTL and testbench
=====================================

# ofdm_symbol_framer

Fixed-length OFDM symbol framer that sits directly upstream of the cyclic prefix inserter. It takes a continuous AXI4-Stream of time-domain samples from the IFFT and emits symbols of exactly 2^cfg_log2_len samples. Each output symbol has TLAST on its final sample and TUSER on its first sample. If a symbol from upstream ends early, the framer zero-pads it to full length, so the prefix inserter always receives complete symbols.

## Interface
Parameters:
- DATA_WIDTH, 32, sample width (packed I/Q).
- MAX_LOG2_LEN, 11, largest supported symbol length exponent (2048 samples).
- MIN_LOG2_LEN, 3, smallest supported symbol length exponent (8 samples).
- CNT_WIDTH, 16, width of the symbol counter.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- cfg_log2_len  in  4  symbol length exponent; sampled only at symbol start.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  upstream end-of-symbol marker (optional use).
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last sample of symbol.
- m_axis_tuser  out  1  first sample of symbol.
- sym_count  out  CNT_WIDTH  completed symbols; wraps modulo 2^CNT_WIDTH.
- pad_event  out  1  one-cycle pulse when a padding run starts.

## Operation
- Internal state:
  - sample index idx, width MAX_LOG2_LEN+1.
  - latched length len, held as last index L = 2^n - 1.
  - FSM with states RUN and PAD.
  - 2-entry output skid buffer.
- Length latch:
  - At each accepted sample with idx == 0 (RUN), or at PAD entry when idx == 0 is impossible, L latches from cfg_log2_len.
  - cfg_log2_len is clamped to [MIN_LOG2_LEN, MAX_LOG2_LEN].
  - Changes to cfg_log2_len mid-symbol have no effect until the next symbol.
- RUN:
  - Each input handshake writes one entry: data, tuser = (idx == 0), tlast = (idx == L).
  - idx increments on each handshake; it resets to 0 when idx == L, and sym_count increments.
  - s_axis_tlast with idx == L: normal end of symbol, no action.
  - s_axis_tlast with idx < L: the sample is forwarded, then the FSM enters PAD and pad_event pulses for one cycle.
  - A symbol that reaches L without s_axis_tlast ends normally; upstream TLAST is not required.
- PAD:
  - s_axis_tready = 0.
  - One zero sample is written per cycle that the skid buffer has space, with tuser = 0 and tlast = (idx == L).
  - After the idx == L write, return to RUN with idx = 0 and increment sym_count.
- s_axis_tready = (state == RUN) && skid buffer not full. It is registered, not combinational from m_axis_tready.
- Output: the skid head drives the m_axis_* signals. An entry pops on m_axis_tvalid && m_axis_tready.
- Simultaneous push and pop: occupancy is unchanged and order is preserved.

## Timing
- Reset values: s_axis_tready = 0 during reset and 1 on the first cycle after release. m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, sym_count, and pad_event are all 0. FSM = RUN, idx = 0, skid buffer empty.
- Latency: a sample accepted at edge k appears on m_axis_* after edge k (valid in cycle k+1) when the buffer was empty.
- Throughput: one sample per cycle sustained while m_axis_tready = 1.
- Padding: runs at one sample per cycle under no backpressure. The first padded sample is valid 1 cycle after the early-TLAST sample is output.
- sym_count updates on the same edge as the write of the tlast entry, not on its output handshake.
- m_axis_tdata, m_axis_tlast, and m_axis_tuser are held stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Reset mid-symbol: the partial symbol and buffer contents are discarded immediately, with no padding. The next accepted sample starts a new symbol with tuser = 1.

## Test plan
- cfg = 3, 16 samples 1..16, m_axis_tready = 1 -> tuser on 1 and 9; tlast on 8 and 16; sym_count = 2; no gaps after the first output.
- cfg = 3, samples 1..5 with tlast on 5 -> output 1..5 then 0, 0, 0; tlast on the 3rd zero; pad_event pulses once; s_axis_tready = 0 for 3 cycles; sym_count = 1.
- cfg = 3, 32 samples, m_axis_tready random at 50% -> output sequence identical to input; tlast every 8th sample; no drops or duplicates; stable data while stalled.
- cfg = 3, changed to 4 after the 3rd sample -> first symbol 8 samples, second 16 samples; cfg = 15 -> 2048-sample symbol; cfg = 1 -> 8-sample symbol.
- tlast exactly on the 8th sample with cfg = 3 -> no padding, pad_event = 0.
- ARESET asserted asynchronously after 4 of 8 samples -> outputs go to 0 immediately; after release, next sample 0xA5 comes out with tuser = 1; sym_count = 0.

Source files
------------

// File: rtl/ofdm_symbol_framer_if.sv
// Stream bundle between the IFFT-side source, the framer and the
// cyclic prefix inserter. The s_axis_* group feeds the framer and the
// m_axis_* group leaves it.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready
// are both 1. A source holds tdata/tlast/tuser steady while tvalid is 1
// and tready is 0, and does not drop tvalid until the beat transfers.
interface ofdm_symbol_framer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    // Framer view: consumes the input stream, produces the framed stream.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // Environment view: drives input samples and accepts framed output.
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/ofdm_symbol_framer.sv
// Fixed-length OFDM symbol framer. Cuts the IFFT sample stream into
// symbols of 2^n samples, marks first (tuser) and last (tlast) samples,
// and zero-pads any symbol that upstream ends early. Output goes through
// a 2-entry skid buffer so s_axis_tready can be a plain register.
module ofdm_symbol_framer #(
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_LOG2_LEN = 11,
    parameter int MIN_LOG2_LEN = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [3:0]           cfg_log2_len,
    ofdm_symbol_framer_if.slave  axis,
    output logic [CNT_WIDTH-1:0] sym_count,
    output logic                 pad_event,
    output logic                 fsmState
);
    localparam int IDX_W = MAX_LOG2_LEN + 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_PAD = 1'b1
    } state_t;

    typedef struct packed {
        logic                  user;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t               state, stateNext;
    logic [IDX_W-1:0]     idx, idxNext;
    logic [IDX_W-1:0]     lastIdx, lastIdxNext;
    logic [IDX_W-1:0]     effLast, cfgLast;
    logic [3:0]           cfgClamped;
    logic [CNT_WIDTH-1:0] symCountNext;
    logic                 padEventNext;

    entry_t               ent0, ent1, ent0Next, ent1Next, pushEntry;
    logic [1:0]           occ, occNext;
    logic                 push, pop;
    logic                 readyReg, readyNext;

    // Clamp the requested exponent and turn it into a last index 2^n - 1.
    always_comb begin
        if (cfg_log2_len < 4'(MIN_LOG2_LEN)) begin
            cfgClamped = 4'(MIN_LOG2_LEN);
        end else if (cfg_log2_len > 4'(MAX_LOG2_LEN)) begin
            cfgClamped = 4'(MAX_LOG2_LEN);
        end else begin
            cfgClamped = cfg_log2_len;
        end
        cfgLast = (IDX_W'(1) << cfgClamped) - IDX_W'(1);
    end

    // FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, symbol bookkeeping and the entry written into the skid buffer.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        lastIdxNext  = lastIdx;
        symCountNext = sym_count;
        padEventNext = 1'b0;
        push         = 1'b0;
        pushEntry    = '0;
        // The first sample of a symbol uses the freshly sampled length so
        // a config change lands exactly on a symbol boundary.
        effLast      = (idx == '0) ? cfgLast : lastIdx;
        case (state)
            ST_RUN: begin
                if (axis.s_axis_tvalid && readyReg) begin
                    push           = 1'b1;
                    pushEntry.user = (idx == '0);
                    pushEntry.last = (idx == effLast);
                    pushEntry.data = axis.s_axis_tdata;
                    lastIdxNext    = effLast;
                    if (idx == effLast) begin
                        idxNext      = '0;
                        symCountNext = sym_count + 1'b1;
                    end else begin
                        idxNext = idx + 1'b1;
                        // Early end from upstream: fill the rest with zeros.
                        if (axis.s_axis_tlast) begin
                            stateNext    = ST_PAD;
                            padEventNext = 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (occ != 2'd2) begin
                    push           = 1'b1;
                    pushEntry.last = (idx == lastIdx);
                    if (idx == lastIdx) begin
                        idxNext      = '0;
                        symCountNext = sym_count + 1'b1;
                        stateNext    = ST_RUN;
                    end else begin
                        idxNext = idx + 1'b1;
                    end
                end
            end
            default: stateNext = ST_RUN;
        endcase
    end

    // Skid buffer update: ent0 is always the head; push/pop together keep order.
    always_comb begin
        pop      = (occ != 2'd0) && axis.m_axis_tready;
        ent0Next = ent0;
        ent1Next = ent1;
        occNext  = occ;
        case ({push, pop})
            2'b10: begin
                if (occ == 2'd0) begin
                    ent0Next = pushEntry;
                end else begin
                    ent1Next = pushEntry;
                end
                occNext = occ + 2'd1;
            end
            2'b01: begin
                ent0Next = ent1;
                occNext  = occ - 2'd1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    ent0Next = pushEntry;
                end else begin
                    ent0Next = ent1;
                    ent1Next = pushEntry;
                end
            end
            default: ;
        endcase
        // Ready for the next cycle is known exactly from next occupancy.
        readyNext = (stateNext == ST_RUN) && (occNext != 2'd2);
    end

    // Datapath registers; reset drops any partial symbol and buffered data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            idx       <= '0;
            lastIdx   <= '0;
            sym_count <= '0;
            pad_event <= 1'b0;
            ent0      <= '0;
            ent1      <= '0;
            occ       <= 2'd0;
            readyReg  <= 1'b0;
        end else begin
            idx       <= idxNext;
            lastIdx   <= lastIdxNext;
            sym_count <= symCountNext;
            pad_event <= padEventNext;
            ent0      <= ent0Next;
            ent1      <= ent1Next;
            occ       <= occNext;
            readyReg  <= readyNext;
        end
    end

    assign axis.s_axis_tready = readyReg;
    assign axis.m_axis_tvalid = (occ != 2'd0);
    assign axis.m_axis_tdata  = ent0.data;
    assign axis.m_axis_tlast  = ent0.last;
    assign axis.m_axis_tuser  = ent0.user;
    assign fsmState           = state;
endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench for ofdm_symbol_framer: framing, padding, backpressure,
// length changes/clamping and asynchronous reset.
`timescale 1ns/1ps
module tb_ofdm_symbol_framer;
    localparam int DW = 32;
    localparam int EW = DW + 2;

    logic        tb_ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  cfg_log2_len;
    logic [15:0] sym_count;
    logic        pad_event;
    logic        fsmState;

    ofdm_symbol_framer_if #(.DATA_WIDTH(DW)) bus();

    ofdm_symbol_framer #(
        .DATA_WIDTH(DW), .MAX_LOG2_LEN(11), .MIN_LOG2_LEN(3), .CNT_WIDTH(16)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .cfg_log2_len(cfg_log2_len), .axis(bus),
        .sym_count(sym_count), .pad_event(pad_event), .fsmState(fsmState)
    );

    // Clock and cycle counter.
    always #5 tb_ACLK = ~tb_ACLK;
    int cycleNum = 0;
    always @(posedge tb_ACLK) cycleNum <= cycleNum + 1;

    // Downstream ready: fixed level or a random bit refreshed each cycle.
    logic randReady = 1'b0;
    logic fixedReady = 1'b1;
    logic rndBit = 1'b1;
    initial begin
        forever begin
            @(posedge tb_ACLK);
            #1;
            rndBit = 1'($urandom_range(0, 1));
        end
    end
    assign bus.m_axis_tready = randReady ? rndBit : fixedReady;

    int passCount = 0;
    int checkCount = 0;

    // Output monitor, sampled on the falling edge.
    logic [DW-1:0] gotData[$];
    logic          gotUser[$];
    logic          gotLast[$];
    int            gotCycle[$];
    int padCount = 0;
    int readyLowCount = 0;
    int stallEvents = 0;
    int stallErrCount = 0;
    logic          stalled = 1'b0;
    logic [EW-1:0] held = '0;
    always @(negedge tb_ACLK) begin
        if (ARESET) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                stallEvents++;
                if (bus.m_axis_tvalid !== 1'b1 ||
                    {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata} !== held)
                    stallErrCount++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                gotData.push_back(bus.m_axis_tdata);
                gotUser.push_back(bus.m_axis_tuser);
                gotLast.push_back(bus.m_axis_tlast);
                gotCycle.push_back(cycleNum);
            end
            if (pad_event) padCount++;
            if (!bus.s_axis_tready) readyLowCount++;
            stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
            held = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
        end
    end

    // Driver: present one sample and hold it until accepted.
    task automatic send_sample(input logic [DW-1:0] d, input logic last);
        int guard = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        forever begin
            @(negedge tb_ACLK);
            if (bus.s_axis_tready === 1'b1) break;
            guard++;
            if (guard > 2000) begin
                checkCount++;
                $display("FAIL send_timeout: sample %h never accepted", d);
                break;
            end
        end
        @(posedge tb_ACLK);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Wait until n outputs beyond base have been seen, bounded.
    task automatic wait_outputs(input int base, input int n, input int limit, input string name);
        int cyc = 0;
        while (gotData.size() < base + n && cyc < limit) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        checkCount++;
        if (gotData.size() < base + n)
            $display("FAIL %s: got %0d outputs, expected %0d", name, gotData.size() - base, n);
        else
            passCount++;
        @(posedge tb_ACLK);
        #1;
    endtask

    // Pulse reset and return aligned just after a rising edge.
    task automatic do_reset();
        ARESET = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        repeat (2) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        ARESET = 1'b0;
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs[8];
        logic [31:0] exp[8];
        string names[8];
        ARESET = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        cfg_log2_len = 4'd3;
        repeat (3) @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        obs = '{32'(bus.s_axis_tready), 32'(bus.m_axis_tvalid), bus.m_axis_tdata,
                32'(bus.m_axis_tlast), 32'(bus.m_axis_tuser), 32'(sym_count),
                32'(pad_event), 32'(fsmState)};
        exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        names = '{"rst_tready", "rst_tvalid", "rst_tdata", "rst_tlast", "rst_tuser",
                  "rst_sym_count", "rst_pad_event", "rst_state"};
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %h expected %h", names[i], obs[i], exp[i]);
            else
                passCount++;
        end
        ARESET = 1'b0;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        checkCount++;
        if (bus.s_axis_tready !== 1'b1)
            $display("FAIL rst_release_tready: got %b expected 1", bus.s_axis_tready);
        else
            passCount++;
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_basic_stream();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] got;
        int b;
        do_reset();
        cfg_log2_len = 4'd3;
        b = gotData.size();
        for (int i = 0; i < 16; i++) exp_q.push_back({(i % 8) == 0, (i % 8) == 7, DW'(i + 1)});
        for (int i = 0; i < 16; i++) send_sample(DW'(i + 1), 1'b0);
        wait_outputs(b, 16, 100, "basic_wait");
        for (int i = 0; i < 16; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            checkCount++;
            if (got !== exp_q[i]) $display("FAIL basic_out[%0d]: got %h expected %h", i, got, exp_q[i]);
            else passCount++;
        end
        checkCount++;
        if (sym_count !== 16'd2) $display("FAIL basic_sym_count: got %0d expected 2", sym_count);
        else passCount++;
        checkCount++;
        if (gotCycle[b + 15] - gotCycle[b] !== 15)
            $display("FAIL basic_no_gaps: span %0d expected 15", gotCycle[b + 15] - gotCycle[b]);
        else passCount++;
    endtask

    task automatic test_early_tlast();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] got;
        int b, pb, rb;
        do_reset();
        cfg_log2_len = 4'd3;
        b = gotData.size();
        pb = padCount;
        rb = readyLowCount;
        for (int i = 0; i < 5; i++) exp_q.push_back({i == 0, 1'b0, DW'(i + 1)});
        exp_q.push_back({1'b0, 1'b0, DW'(0)});
        exp_q.push_back({1'b0, 1'b0, DW'(0)});
        exp_q.push_back({1'b0, 1'b1, DW'(0)});
        for (int i = 0; i < 5; i++) send_sample(DW'(i + 1), i == 4);
        wait_outputs(b, 8, 100, "pad_wait");
        repeat (4) @(negedge tb_ACLK);
        for (int i = 0; i < 8; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            checkCount++;
            if (got !== exp_q[i]) $display("FAIL pad_out[%0d]: got %h expected %h", i, got, exp_q[i]);
            else passCount++;
        end
        checkCount++;
        if (padCount - pb !== 1) $display("FAIL pad_event_count: got %0d expected 1", padCount - pb);
        else passCount++;
        checkCount++;
        if (readyLowCount - rb !== 3) $display("FAIL pad_tready_low: got %0d expected 3", readyLowCount - rb);
        else passCount++;
        checkCount++;
        if (sym_count !== 16'd1) $display("FAIL pad_sym_count: got %0d expected 1", sym_count);
        else passCount++;
        checkCount++;
        if (gotCycle[b + 5] - gotCycle[b + 4] !== 1)
            $display("FAIL pad_first_delay: got %0d expected 1", gotCycle[b + 5] - gotCycle[b + 4]);
        else passCount++;
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] got;
        int b, se, sb;
        do_reset();
        cfg_log2_len = 4'd3;
        b = gotData.size();
        se = stallEvents;
        sb = stallErrCount;
        randReady = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back({(i % 8) == 0, (i % 8) == 7, DW'(32'h100 + i)});
        for (int i = 0; i < 32; i++) send_sample(DW'(32'h100 + i), 1'b0);
        wait_outputs(b, 32, 1000, "bp_wait");
        randReady = 1'b0;
        fixedReady = 1'b1;
        repeat (5) @(negedge tb_ACLK);
        for (int i = 0; i < 32; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            checkCount++;
            if (got !== exp_q[i]) $display("FAIL bp_out[%0d]: got %h expected %h", i, got, exp_q[i]);
            else passCount++;
        end
        checkCount++;
        if (gotData.size() - b !== 32) $display("FAIL bp_count: got %0d expected 32", gotData.size() - b);
        else passCount++;
        checkCount++;
        if (sym_count !== 16'd4) $display("FAIL bp_sym_count: got %0d expected 4", sym_count);
        else passCount++;
        checkCount++;
        if (stallErrCount - sb !== 0) $display("FAIL bp_stall_hold: got %0d changes expected 0", stallErrCount - sb);
        else passCount++;
        checkCount++;
        if (stallEvents - se <= 0) $display("FAIL bp_stalls_seen: got %0d expected >0", stallEvents - se);
        else passCount++;
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_cfg_change();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] got;
        int b;
        do_reset();
        cfg_log2_len = 4'd3;
        b = gotData.size();
        for (int i = 0; i < 24; i++) exp_q.push_back({i == 0 || i == 8, i == 7 || i == 23, DW'(i + 1)});
        for (int i = 0; i < 3; i++) send_sample(DW'(i + 1), 1'b0);
        cfg_log2_len = 4'd4;
        for (int i = 3; i < 24; i++) send_sample(DW'(i + 1), 1'b0);
        wait_outputs(b, 24, 100, "cfg_wait");
        for (int i = 0; i < 24; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            checkCount++;
            if (got !== exp_q[i]) $display("FAIL cfg_out[%0d]: got %h expected %h", i, got, exp_q[i]);
            else passCount++;
        end
        checkCount++;
        if (sym_count !== 16'd2) $display("FAIL cfg_sym_count: got %0d expected 2", sym_count);
        else passCount++;
    endtask

    task automatic test_cfg_clamp();
        logic [EW-1:0] exp_q[$];
        logic [EW-1:0] got, e;
        int b, errs;
        // Exponent 15 clamps to 11: one 2048-sample symbol.
        do_reset();
        cfg_log2_len = 4'd15;
        b = gotData.size();
        for (int i = 0; i < 2048; i++) send_sample(DW'(i + 1), 1'b0);
        wait_outputs(b, 2048, 200, "clamp_hi_wait");
        errs = 0;
        for (int i = 0; i < 2048; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            e = {i == 0, i == 2047, DW'(i + 1)};
            if (got !== e) errs++;
        end
        checkCount++;
        if (errs !== 0) $display("FAIL clamp_hi_stream: got %0d bad samples expected 0", errs);
        else passCount++;
        checkCount++;
        if (sym_count !== 16'd1) $display("FAIL clamp_hi_sym_count: got %0d expected 1", sym_count);
        else passCount++;
        // Exponent 1 clamps to 3: 8-sample symbols.
        do_reset();
        cfg_log2_len = 4'd1;
        b = gotData.size();
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 0, i == 7, DW'(32'h50 + i)});
        for (int i = 0; i < 8; i++) send_sample(DW'(32'h50 + i), 1'b0);
        wait_outputs(b, 8, 100, "clamp_lo_wait");
        for (int i = 0; i < 8; i++) begin
            got = {gotUser[b + i], gotLast[b + i], gotData[b + i]};
            checkCount++;
            if (got !== exp_q[i]) $display("FAIL clamp_lo_out[%0d]: got %h expected %h", i, got, exp_q[i]);
            else passCount++;
        end
        checkCount++;
        if (sym_count !== 16'd1) $display("FAIL clamp_lo_sym_count: got %0d expected 1", sym_count);
        else passCount++;
    endtask

    task automatic test_exact_tlast();
        int b, pb;
        do_reset();
        cfg_log2_len = 4'd3;
        b = gotData.size();
        pb = padCount;
        for (int i = 0; i < 8; i++) send_sample(DW'(32'hE0 + i), i == 7);
        wait_outputs(b, 8, 100, "exact_wait");
        repeat (10) @(negedge tb_ACLK);
        checkCount++;
        if (gotData.size() - b !== 8) $display("FAIL exact_count: got %0d expected 8", gotData.size() - b);
        else passCount++;
        checkCount++;
        if ({gotLast[b + 7], gotData[b + 7]} !== {1'b1, DW'(32'hE7)})
            $display("FAIL exact_last: got %b/%h expected 1/000000e7", gotLast[b + 7], gotData[b + 7]);
        else passCount++;
        checkCount++;
        if (padCount - pb !== 0) $display("FAIL exact_pad_event: got %0d expected 0", padCount - pb);
        else passCount++;
        checkCount++;
        if (sym_count !== 16'd1) $display("FAIL exact_sym_count: got %0d expected 1", sym_count);
        else passCount++;
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] got;
        int b;
        do_reset();
        cfg_log2_len = 4'd3;
        fixedReady = 1'b1;
        for (int i = 0; i < 4; i++) send_sample(DW'(i + 1), 1'b0);
        #2;
        checkCount++;
        if (bus.m_axis_tvalid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", bus.m_axis_tvalid);
        else passCount++;
        ARESET = 1'b1;
        #1;
        checkCount++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.s_axis_tready, fsmState} !== 5'b0)
            $display("FAIL areset_flags: got %b expected 00000",
                     {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.s_axis_tready, fsmState});
        else passCount++;
        checkCount++;
        if (bus.m_axis_tdata !== '0) $display("FAIL areset_tdata: got %h expected 0", bus.m_axis_tdata);
        else passCount++;
        @(negedge tb_ACLK);
        ARESET = 1'b0;
        @(posedge tb_ACLK);
        #1;
        b = gotData.size();
        send_sample(DW'(32'hA5), 1'b0);
        wait_outputs(b, 1, 50, "areset_wait");
        got = {gotUser[b], gotLast[b], gotData[b]};
        checkCount++;
        if (got !== {1'b1, 1'b0, DW'(32'hA5)}) $display("FAIL areset_first: got %h expected %h", got, {1'b1, 1'b0, DW'(32'hA5)});
        else passCount++;
        checkCount++;
        if (sym_count !== 16'd0) $display("FAIL areset_sym_count: got %0d expected 0", sym_count);
        else passCount++;
    endtask

    // Test sequence and final report.
    initial begin
        ARESET = 1'b1;
        cfg_log2_len = 4'd3;
        bus.s_axis_tdata = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0;
        test_reset();
        test_basic_stream();
        test_early_tlast();
        test_backpressure();
        test_cfg_change();
        test_cfg_clamp();
        test_exact_tlast();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
